// File: rtl/alu_seq_driver.sv
// Sequences single or sweeping (000..111) operations onto a combinational ALU,
// waits a fixed settle time, then presents each result on a valid/ready response port.
module alu_seq_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [2:0] cmd_sel,
  input  logic       cmd_sweep,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_sel,
  input  logic [3:0] alu_out,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [2:0] rsp_sel,
  output logic [3:0] rsp_out,
  output logic       rsp_carry,
  output logic       rsp_last,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Counter runs SETTLE_CYCLES-1 down to 0, so DRIVE spans exactly SETTLE_CYCLES edges.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [3:0] settle_q;
  logic       sweep_q;
  logic       cmd_ready_q;
  logic       busy_q;
  logic [3:0] alu_a_q;
  logic [3:0] alu_b_q;
  logic [2:0] alu_sel_q;
  logic       rsp_valid_q;
  logic [2:0] rsp_sel_q;
  logic [3:0] rsp_out_q;
  logic       rsp_carry_q;
  logic       rsp_last_q;
  logic [7:0] op_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      sweep_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_sel_q   <= '0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            alu_a_q     <= cmd_a;
            alu_b_q     <= cmd_b;
            alu_sel_q   <= cmd_sweep ? 3'b000 : cmd_sel;
            sweep_q     <= cmd_sweep;
            settle_q    <= SETTLE_LOAD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end
        end
        DRIVE: begin
          if (settle_q == 4'd0) begin
            rsp_out_q   <= alu_out;
            rsp_carry_q <= alu_carry;
            rsp_sel_q   <= alu_sel_q;
            rsp_last_q  <= !sweep_q || (alu_sel_q == 3'b111);
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else begin
            settle_q <= settle_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count_q  <= op_count_q + 8'd1;
            if (rsp_last_q) begin
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE;
            end else begin
              alu_sel_q <= alu_sel_q + 3'd1;
              settle_q  <= SETTLE_LOAD;
              state_q   <= DRIVE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sel   = rsp_sel_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_last  = rsp_last_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver: one instance at SETTLE_CYCLES=1, one at 4,
// each closed around a behavioural ALU model.
`timescale 1ns/1ps
module tb_alu_seq_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cmd_valid, cmd_valid4, cmd_sweep, rsp_ready;
  logic [3:0] cmd_a, cmd_b;
  logic [2:0] cmd_sel;

  logic       cmd_ready, rsp_valid, rsp_carry, rsp_last, busy, alu_carry;
  logic [3:0] alu_a, alu_b, rsp_out, alu_out;
  logic [2:0] alu_sel, rsp_sel;
  logic [7:0] op_count;

  logic       cmd_ready4, rsp_valid4, rsp_carry4, rsp_last4, busy4, alu_carry4;
  logic [3:0] alu_a4, alu_b4, rsp_out4, alu_out4;
  logic [2:0] alu_sel4, rsp_sel4;
  logic [7:0] op_count4;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp35 [8] = '{4'h1, 4'h7, 4'h6, 4'h8, 4'hE, 4'hC, 4'hA, 4'h2};
  logic [3:0] exp96 [8] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h3, 4'h6, 4'hC, 4'h3};

  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
    logic [4:0] r;
    r = '0;
    case (sel)
      3'd0: r = {1'b0, a & b};
      3'd1: r = {1'b0, a | b};
      3'd2: r = {1'b0, a ^ b};
      3'd3: r = {1'b0, a} + {1'b0, b};
      3'd4: r = {1'b0, a} - {1'b0, b};
      3'd5: r = {1'b0, ~a};
      3'd6: r = {1'b0, b[2:0], 1'b0};
      default: r = {2'b00, b[3:1]};
    endcase
    return r;
  endfunction

  assign {alu_carry, alu_out}   = alu_model(alu_a, alu_b, alu_sel);
  assign {alu_carry4, alu_out4} = alu_model(alu_a4, alu_b4, alu_sel4);

  logic [9:0]  rsp_bus, rsp_bus4;
  logic [10:0] alu_bus, alu_bus4;
  assign rsp_bus  = {rsp_valid, rsp_sel, rsp_out, rsp_carry, rsp_last};
  assign rsp_bus4 = {rsp_valid4, rsp_sel4, rsp_out4, rsp_carry4, rsp_last4};
  assign alu_bus  = {alu_a, alu_b, alu_sel};
  assign alu_bus4 = {alu_a4, alu_b4, alu_sel4};

  alu_seq_driver #(.SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_sweep(cmd_sweep),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .alu_carry(alu_carry), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sel(rsp_sel), .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .rsp_last(rsp_last), .busy(busy), .op_count(op_count)
  );

  alu_seq_driver #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_sweep(cmd_sweep),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_out(alu_out4),
    .alu_carry(alu_carry4), .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
    .rsp_sel(rsp_sel4), .rsp_out(rsp_out4), .rsp_carry(rsp_carry4),
    .rsp_last(rsp_last4), .busy(busy4), .op_count(op_count4)
  );

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_bus, alu_bus, op_count} !== 31'd0) begin
      errors++;
      $display("FAIL reset_state: got %h want 0", {cmd_ready, busy, rsp_bus, alu_bus, op_count});
    end
    checks++;
    if ({cmd_ready4, busy4, rsp_bus4, alu_bus4, op_count4} !== 31'd0) begin
      errors++;
      $display("FAIL reset_state4: got %h want 0", {cmd_ready4, busy4, rsp_bus4, alu_bus4, op_count4});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, cmd_ready4} !== 3'b101) begin
      errors++;
      $display("FAIL reset_release: got %b want 101", {cmd_ready, busy, cmd_ready4});
    end
    $display("reset: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_single;
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 3'd3; cmd_sweep = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, busy, rsp_valid, alu_bus} !== {1'b0, 1'b1, 1'b0, 4'd3, 4'd5, 3'd3}) begin
      errors++;
      $display("FAIL single_accept: got %h want %h", {cmd_ready, busy, rsp_valid, alu_bus},
               {1'b0, 1'b1, 1'b0, 4'd3, 4'd5, 3'd3});
    end
    @(negedge clk);
    checks++;
    if (rsp_bus !== {1'b1, 3'd3, 4'd8, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_rsp: got %h want %h", rsp_bus, {1'b1, 3'd3, 4'd8, 1'b0, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, cmd_ready, op_count} !== {1'b0, 1'b0, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL single_done: got %h want %h", {rsp_valid, busy, cmd_ready, op_count},
               {1'b0, 1'b0, 1'b1, 8'd1});
    end
    $display("single: A=3 B=5 sel=3 rsp_out=%h carry=%b op_count=%0d", rsp_out, rsp_carry, op_count);
  endtask

  task automatic test_sweep;
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 3'd5; cmd_sweep = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({busy, alu_sel} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL sweep_start_sel: got %h want %h", {busy, alu_sel}, {1'b1, 3'd0});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_bus !== {1'b1, 3'(i), exp35[i], (i == 4), (i == 7)}) begin
        errors++;
        $display("FAIL sweep_rsp%0d: got %h want %h", i, rsp_bus,
                 {1'b1, 3'(i), exp35[i], (i == 4), (i == 7)});
      end
      $display("sweep: sel=%0d rsp_out=%h carry=%b last=%b", rsp_sel, rsp_out, rsp_carry, rsp_last);
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready} !== {1'b0, (i == 7)}) begin
        errors++;
        $display("FAIL sweep_hs%0d: got %b want %b", i, {rsp_valid, cmd_ready}, {1'b0, (i == 7)});
      end
    end
    checks++;
    if ({op_count, alu_sel, busy} !== {8'd9, 3'd7, 1'b0}) begin
      errors++;
      $display("FAIL sweep_end: got %h want %h", {op_count, alu_sel, busy}, {8'd9, 3'd7, 1'b0});
    end
  endtask

  task automatic test_backpressure;
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({rsp_valid, op_count} !== {1'b0, 8'd9}) begin
      errors++;
      $display("FAIL idle_ready: got %h want %h", {rsp_valid, op_count}, {1'b0, 8'd9});
    end
    cmd_a = 4'd9; cmd_b = 4'd6; cmd_sweep = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_a = 4'd1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({rsp_bus, alu_bus, op_count} !== {1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 4'd9, 4'd6, 3'd0, 8'd9}) begin
        errors++;
        $display("FAIL bp_hold%0d: got %h want %h", k, {rsp_bus, alu_bus, op_count},
                 {1'b1, 3'd0, 4'd0, 1'b0, 1'b0, 4'd9, 4'd6, 3'd0, 8'd9});
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, alu_sel, op_count} !== {1'b0, 3'd1, 8'd10}) begin
      errors++;
      $display("FAIL bp_release: got %h want %h", {rsp_valid, alu_sel, op_count}, {1'b0, 3'd1, 8'd10});
    end
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_bus !== {1'b1, 3'(i), exp96[i], 1'b0, (i == 7)}) begin
        errors++;
        $display("FAIL bp_rsp%0d: got %h want %h", i, rsp_bus, {1'b1, 3'(i), exp96[i], 1'b0, (i == 7)});
      end
      $display("backpressure: sel=%0d rsp_out=%h", rsp_sel, rsp_out);
      @(negedge clk);
    end
    checks++;
    if ({op_count, busy} !== {8'd17, 1'b0}) begin
      errors++;
      $display("FAIL bp_count: got %h want %h", {op_count, busy}, {8'd17, 1'b0});
    end
  endtask

  task automatic test_cmd_held;
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 3'd0; cmd_sweep = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_a = 4'd12; cmd_b = 4'd1; cmd_sel = 3'd1; cmd_sweep = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_bus, alu_a, alu_b} !== {1'b1, 3'(i), exp35[i], (i == 4), (i == 7), 4'd3, 4'd5}) begin
        errors++;
        $display("FAIL held_rsp%0d: got %h want %h", i, {rsp_bus, alu_a, alu_b},
                 {1'b1, 3'(i), exp35[i], (i == 4), (i == 7), 4'd3, 4'd5});
      end
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, busy} !== {1'b0, (i == 7), (i != 7)}) begin
        errors++;
        $display("FAIL held_hs%0d: got %b want %b", i, {rsp_valid, cmd_ready, busy},
                 {1'b0, (i == 7), (i != 7)});
      end
    end
    $display("cmd_held: sweep done op_count=%0d, second command pending", op_count);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({busy, cmd_ready, alu_bus} !== {1'b1, 1'b0, 4'd12, 4'd1, 3'd1}) begin
      errors++;
      $display("FAIL held_second_accept: got %h want %h", {busy, cmd_ready, alu_bus},
               {1'b1, 1'b0, 4'd12, 4'd1, 3'd1});
    end
    @(negedge clk);
    checks++;
    if (rsp_bus !== {1'b1, 3'd1, 4'd13, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL held_second_rsp: got %h want %h", rsp_bus, {1'b1, 3'd1, 4'd13, 1'b0, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({op_count, busy} !== {8'd26, 1'b0}) begin
      errors++;
      $display("FAIL held_count: got %h want %h", {op_count, busy}, {8'd26, 1'b0});
    end
  endtask

  task automatic test_settle4;
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 3'd4; cmd_sweep = 1'b0; rsp_ready = 1'b1;
    cmd_valid4 = 1'b1;
    @(negedge clk);
    cmd_valid4 = 1'b0;
    for (int k = 1; k < 4; k++) begin
      checks++;
      if ({busy4, cmd_ready4, rsp_valid4, alu_bus4} !== {1'b1, 1'b0, 1'b0, 4'd3, 4'd5, 3'd4}) begin
        errors++;
        $display("FAIL settle4_wait%0d: got %h want %h", k, {busy4, cmd_ready4, rsp_valid4, alu_bus4},
                 {1'b1, 1'b0, 1'b0, 4'd3, 4'd5, 3'd4});
      end
      @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (rsp_bus4 !== {1'b1, 3'd4, 4'hE, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL settle4_rsp: got %h want %h", rsp_bus4, {1'b1, 3'd4, 4'hE, 1'b1, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({rsp_valid4, op_count4, cmd_ready4, op_count} !== {1'b0, 8'd1, 1'b1, 8'd26}) begin
      errors++;
      $display("FAIL settle4_done: got %h want %h", {rsp_valid4, op_count4, cmd_ready4, op_count},
               {1'b0, 8'd1, 1'b1, 8'd26});
    end
    $display("settle4: SUB 3-5 rsp_out=%h carry=%b", rsp_out4, rsp_carry4);
  endtask

  task automatic test_mid_reset;
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_sweep = 1'b1; rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    checks++;
    if (rsp_bus !== {1'b1, 3'd3, 4'd8, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_pre: got %h want %h", rsp_bus, {1'b1, 3'd3, 4'd8, 1'b0, 1'b0});
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_bus, alu_bus, op_count, op_count4} !== 39'd0) begin
      errors++;
      $display("FAIL midrst_zero: got %h want 0", {cmd_ready, busy, rsp_bus, alu_bus, op_count, op_count4});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cmd_ready, busy, rsp_valid, op_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL midrst_release: got %h want %h", {cmd_ready, busy, rsp_valid, op_count},
               {1'b1, 1'b0, 1'b0, 8'd0});
    end
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, rsp_valid, op_count, alu_sel} !== 13'd0) begin
      errors++;
      $display("FAIL midrst_noresume: got %h want 0", {busy, rsp_valid, op_count, alu_sel});
    end
    $display("mid_reset: op_count=%0d cmd_ready=%b", op_count, cmd_ready);
  endtask

  task automatic test_wrap;
    bit ok;
    cmd_a = 4'd3; cmd_b = 4'd5; cmd_sel = 3'd3; cmd_sweep = 1'b0; rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    for (int j = 1; j <= 256; j++) begin
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        if (rsp_valid) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL wrap_timeout%0d: got rsp_valid=0 want rsp_valid=1 within 20 cycles", j);
        break;
      end
      if (j == 256) cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp_valid, op_count} !== {1'b0, 8'(j)}) begin
        errors++;
        $display("FAIL wrap_count%0d: got %h want %h", j, {rsp_valid, op_count}, {1'b0, 8'(j)});
      end
    end
    checks++;
    if ({op_count, busy} !== {8'd0, 1'b0}) begin
      errors++;
      $display("FAIL wrap_final: got %h want %h", {op_count, busy}, {8'd0, 1'b0});
    end
    $display("wrap: 256 handshakes, op_count=%0d", op_count);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_valid4 = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_sweep = 1'b0;
    test_reset;
    test_single;
    test_sweep;
    test_backpressure;
    test_cmd_held;
    test_settle4;
    test_mid_reset;
    test_wrap;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
